// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_pkg
// Purpose  : Shared widths, requester ids and helpers for the register-file
//            write-port arbiter, its interface and its decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH  = 16;

  // Requester ids as carried on last_grant.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MDU = 1'b1;

  // Register 0 is hardwired zero and never receives an enable pulse.
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [NUM_REGS-1:0]   wen_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t value);
    return (value == CNT_MAX) ? value : value + cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Bundles both writeback requester handshakes and the registered
//            register-file write bus.
// Ports    : master - requester/register-file side (drives req*_valid/addr/
//                     data, observes readies and the write bus)
//            slave  - arbiter side (drives readies, write bus, last_grant,
//                     conflict_cnt)
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic  req0_valid;
  addr_t req0_addr;
  data_t req0_data;
  logic  req0_ready;

  logic  req1_valid;
  addr_t req1_addr;
  data_t req1_data;
  logic  req1_ready;

  wen_t  wr_enable;
  addr_t wr_addr;
  data_t wr_data;
  logic  last_grant;
  cnt_t  conflict_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  wr_enable, wr_addr, wr_data, last_grant, conflict_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output wr_enable, wr_addr, wr_data, last_grant, conflict_cnt
  );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_decoder_5to32.sv
`default_nettype none
// ============================================================================
// Module   : decoder_5to32
// Purpose  : Combinational one-hot decode of a register address into the
//            per-register write enables. All-zero output when not enabled.
// Ports    : addr   in  ADDR_WIDTH  register address to decode
//            enable in  1           gate; low gives an all-zero output
//            onehot out NUM_REGS    one-hot write enable
// Revision : 1.0 - initial release
// ============================================================================
module decoder_5to32
  import regfile_write_arbiter_pkg::*;
(
  input  addr_t addr,
  input  logic  enable,
  output wen_t  onehot
);

  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the register file's single write
//            port between the ALU writeback (req0) and the mult/div unit
//            (req1). Grants are combinational; the granted write is
//            registered and presented one cycle later as a one-hot enable,
//            address and data. Also counts contention cycles (saturating).
// Ports    : clock    in  rising-edge clock
//            clear_n  in  asynchronous active-low reset
//            bus      slave modport of regfile_write_arbiter_if
//                     (req0/req1 handshakes, wr_enable/wr_addr/wr_data,
//                      last_grant, conflict_cnt)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                          clock,
  input  logic                          clear_n,
  regfile_write_arbiter_if.slave        bus
);

  logic  w_both_valid;
  logic  w_grant0;
  logic  w_grant1;
  logic  w_any_grant;
  logic  w_dec_enable;
  addr_t w_grant_addr;
  data_t w_grant_data;
  wen_t  w_onehot;

  wen_t  r_wr_enable;
  addr_t r_wr_addr;
  data_t r_wr_data;
  logic  r_last_grant;
  cnt_t  r_conflict_cnt;

  // On contention the requester that did not win last time goes first;
  // otherwise any lone requester wins. The two terms are mutually exclusive.
  assign w_both_valid = bus.req0_valid & bus.req1_valid;
  assign w_grant0     = bus.req0_valid & (~bus.req1_valid | (r_last_grant != REQ_ALU));
  assign w_grant1     = bus.req1_valid & (~bus.req0_valid | (r_last_grant != REQ_MDU));
  assign w_any_grant  = w_grant0 | w_grant1;

  assign w_grant_addr = w_grant1 ? bus.req1_addr : bus.req0_addr;
  assign w_grant_data = w_grant1 ? bus.req1_data : bus.req0_data;

  // Writes to the zero register still handshake but never pulse an enable.
  assign w_dec_enable = w_any_grant & (w_grant_addr != REG_ZERO);

  decoder_5to32 u_decoder (
    .addr   (w_grant_addr),
    .enable (w_dec_enable),
    .onehot (w_onehot)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_wr_enable    <= '0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      // Pretend req1 won last so req0 takes the first tie after reset.
      r_last_grant   <= REQ_MDU;
      r_conflict_cnt <= '0;
    end else begin
      // Enable is a single-cycle pulse: re-evaluated every edge.
      r_wr_enable <= w_onehot;
      if (w_any_grant) begin
        r_wr_addr    <= w_grant_addr;
        r_wr_data    <= w_grant_data;
        r_last_grant <= w_grant1 ? REQ_MDU : REQ_ALU;
      end
      if (w_both_valid) begin
        r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
    end
  end

  assign bus.req0_ready   = w_grant0;
  assign bus.req1_ready   = w_grant1;
  assign bus.wr_enable    = r_wr_enable;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.last_grant   = r_last_grant;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter: directed vector
//            table, hand-written reset/saturation sequences and a random
//            phase checked against a behavioural reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic  v0;
    addr_t a0;
    data_t d0;
    logic  v1;
    addr_t a1;
    data_t d1;
    logic  r0;
    logic  r1;
    wen_t  en;
    addr_t addr;
    data_t data;
    logic  last;
    cnt_t  cnt;
  } vec_t;

  vec_t vecs [9];

  // Reference model state: what the write port should show after each edge.
  logic  m_last;
  cnt_t  m_cnt;
  addr_t m_addr;
  data_t m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is positioned just after a rising edge. Drives one cycle of
  // requests, checks readies mid-cycle, then checks the registered outputs
  // just after the next edge.
  task automatic do_cycle(input logic v0, input addr_t a0, input data_t d0,
                          input logic v1, input addr_t a1, input data_t d1,
                          input logic er0, input logic er1, input wen_t een,
                          input addr_t eaddr, input data_t edata,
                          input logic elast, input cnt_t ecnt);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    #2;
    check("req0_ready", 64'(bus.req0_ready), 64'(er0));
    check("req1_ready", 64'(bus.req1_ready), 64'(er1));
    @(posedge clock);
    #1;
    check("wr_enable", 64'(bus.wr_enable), 64'(een));
    check("wr_addr", 64'(bus.wr_addr), 64'(eaddr));
    check("wr_data", 64'(bus.wr_data), 64'(edata));
    check("last_grant", 64'(bus.last_grant), 64'(elast));
    check("conflict_cnt", 64'(bus.conflict_cnt), 64'(ecnt));
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic apply_reset();
    idle_inputs();
    clear_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
    m_last = 1'b1; m_cnt = '0; m_addr = '0; m_data = '0;
    check("rst_wr_enable", 64'(bus.wr_enable), 64'(0));
    check("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
    check("rst_wr_data", 64'(bus.wr_data), 64'(0));
    check("rst_last_grant", 64'(bus.last_grant), 64'(1));
    check("rst_conflict_cnt", 64'(bus.conflict_cnt), 64'(0));
  endtask

  // One model-checked cycle: the winner is chosen from the arbitration
  // rules, then the expected post-edge write-port contents follow from it.
  task automatic model_cycle(input logic v0, input addr_t a0, input data_t d0,
                             input logic v1, input addr_t a1, input data_t d1,
                             output int winner);
    wen_t  een;
    addr_t waddr;
    winner = -1;
    if (v0 && v1)  winner = (m_last == 1'b1) ? 0 : 1;
    else if (v0)   winner = 0;
    else if (v1)   winner = 1;
    waddr = (winner == 1) ? a1 : a0;
    een = '0;
    if (winner >= 0 && int'(waddr) != 0) een = wen_t'(1) << waddr;
    if (v0 && v1 && int'(m_cnt) < (2 ** CNT_WIDTH) - 1) m_cnt = m_cnt + 1'b1;
    if (winner >= 0) begin
      m_last = (winner == 1);
      m_addr = waddr;
      m_data = (winner == 1) ? d1 : d0;
    end
    do_cycle(v0, a0, d0, v1, a1, d1, winner == 0, winner == 1, een,
             m_addr, m_data, m_last, m_cnt);
  endtask

  initial begin
    logic  p0_v, p1_v;
    addr_t p0_a, p1_a;
    data_t p0_d, p1_d;
    int    win;

    // Directed vectors, applied back to back from reset.
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 32'h0000_0020, 5'd5,  32'hDEADBEEF, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 5'd1,  32'h11, 1'b1, 5'd2, 32'h22,
                1'b0, 1'b1, 32'h0000_0004, 5'd2,  32'h22, 1'b1, 16'd1};
    vecs[2] = '{1'b1, 5'd1,  32'h11, 1'b1, 5'd2, 32'h22,
                1'b1, 1'b0, 32'h0000_0002, 5'd1,  32'h11, 1'b0, 16'd2};
    vecs[3] = '{1'b1, 5'd1,  32'h11, 1'b1, 5'd2, 32'h22,
                1'b0, 1'b1, 32'h0000_0004, 5'd2,  32'h22, 1'b1, 16'd3};
    vecs[4] = '{1'b1, 5'd1,  32'h11, 1'b1, 5'd2, 32'h22,
                1'b1, 1'b0, 32'h0000_0002, 5'd1,  32'h11, 1'b0, 16'd4};
    vecs[5] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd0, 32'hFFFFFFFF,
                1'b0, 1'b1, 32'h0000_0000, 5'd0,  32'hFFFFFFFF, 1'b1, 16'd4};
    vecs[6] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 32'h0000_0000, 5'd0,  32'hFFFFFFFF, 1'b1, 16'd4};
    vecs[7] = '{1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 32'h8000_0000, 5'd31, 32'h12345678, 1'b0, 16'd4};
    vecs[8] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 32'h0000_0000, 5'd31, 32'h12345678, 1'b0, 16'd4};

    apply_reset();
    for (int i = 0; i < 9; i++) begin
      do_cycle(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1,
               vecs[i].r0, vecs[i].r1, vecs[i].en, vecs[i].addr, vecs[i].data,
               vecs[i].last, vecs[i].cnt);
    end

    // Reset mid-cycle right after a grant, with both requesters waiting.
    apply_reset();
    do_cycle(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,
             1'b1, 1'b0, 32'h0000_0008, 5'd3, 32'hA5A5A5A5, 1'b0, 16'd0);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd4; bus.req0_data = 32'hB0B0B0B0;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd6; bus.req1_data = 32'hC0C0C0C0;
    #2;
    clear_n = 1'b0;
    #1;
    check("async_rst_wr_enable", 64'(bus.wr_enable), 64'(0));
    check("async_rst_last_grant", 64'(bus.last_grant), 64'(1));
    @(posedge clock);
    #1;
    check("rst_no_pulse_wr_enable", 64'(bus.wr_enable), 64'(0));
    check("rst_no_pulse_cnt", 64'(bus.conflict_cnt), 64'(0));
    clear_n = 1'b1;
    #2;
    check("post_rst_req0_ready", 64'(bus.req0_ready), 64'(1));
    check("post_rst_req1_ready", 64'(bus.req1_ready), 64'(0));
    @(posedge clock);
    #1;
    check("post_rst_wr_enable", 64'(bus.wr_enable), 64'(32'h0000_0010));
    check("post_rst_wr_data", 64'(bus.wr_data), 64'(32'hB0B0B0B0));
    check("post_rst_last_grant", 64'(bus.last_grant), 64'(0));
    check("post_rst_cnt", 64'(bus.conflict_cnt), 64'(1));

    // Conflict counter saturation.
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h1;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h2;
    repeat ((2 ** CNT_WIDTH) - 2) @(posedge clock);
    #1;
    check("sat_cnt_below_max", 64'(bus.conflict_cnt), 64'(16'hFFFE));
    @(posedge clock);
    #1;
    check("sat_cnt_at_max", 64'(bus.conflict_cnt), 64'(16'hFFFF));
    repeat (4) @(posedge clock);
    #1;
    check("sat_cnt_held", 64'(bus.conflict_cnt), 64'(16'hFFFF));

    // Random phase: requesters hold their request until granted, may drop
    // it occasionally, and issue fresh requests at random.
    apply_reset();
    p0_v = 1'b0; p1_v = 1'b0;
    p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0_v && $urandom_range(0, 2) != 0) begin
        p0_v = 1'b1; p0_a = addr_t'($urandom_range(0, NUM_REGS - 1)); p0_d = $urandom;
      end else if (p0_v && $urandom_range(0, 7) == 0) begin
        p0_v = 1'b0;
      end
      if (!p1_v && $urandom_range(0, 2) != 0) begin
        p1_v = 1'b1; p1_a = addr_t'($urandom_range(0, NUM_REGS - 1)); p1_d = $urandom;
      end else if (p1_v && $urandom_range(0, 7) == 0) begin
        p1_v = 1'b0;
      end
      model_cycle(p0_v, p0_a, p0_d, p1_v, p1_a, p1_d, win);
      if (win == 0) p0_v = 1'b0;
      if (win == 1) p1_v = 1'b0;
    end

    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
